// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared opcodes, NOP encoding and ID/EX bundle type
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

   localparam logic [6:0]  c_op_lui    = 7'b0110111;
   localparam logic [6:0]  c_op_auipc  = 7'b0010111;
   localparam logic [6:0]  c_op_jal    = 7'b1101111;
   localparam logic [6:0]  c_op_jalr   = 7'b1100111;
   localparam logic [6:0]  c_op_load   = 7'b0000011;
   localparam logic [6:0]  c_op_opimm  = 7'b0010011;
   localparam logic [6:0]  c_op_op     = 7'b0110011;
   localparam logic [6:0]  c_op_branch = 7'b1100011;
   localparam logic [6:0]  c_op_store  = 7'b0100011;

   localparam logic [31:0] c_nop       = 32'h0000_0013;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
   } ex_bundle_t;

   // Write-through: a same-cycle register-file write wins over the stale read.
   function automatic logic [31:0] bypass(input logic        wb_en,
                                          input logic [4:0]  wb_wa,
                                          input logic [31:0] wb_wd,
                                          input logic [4:0]  adr,
                                          input logic [31:0] rs);
      return (wb_en && (wb_wa != 5'd0) && (wb_wa == adr)) ? wb_wd : rs;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit : decode of write/load/source-use flags and load-use stall
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_unit
   import pipeline_pkg::*;
(
   input  logic       i_id_valid,
   input  logic [6:0] i_opcode,
   input  logic [4:0] i_rd,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic       i_flush,
   input  logic       i_ex_valid,
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rd,
   output logic       o_reg_write,
   output logic       o_mem_read,
   output logic       o_stall
);

   logic w_uses_rs1;
   logic w_uses_rs2;
   logic w_hit;

   always_comb begin
      o_reg_write = 1'b0;
      unique case (i_opcode)
         c_op_lui, c_op_auipc, c_op_jal, c_op_jalr,
         c_op_load, c_op_opimm, c_op_op: o_reg_write = (i_rd != 5'd0);
         default:                        o_reg_write = 1'b0;
      endcase
   end

   assign o_mem_read = (i_opcode == c_op_load);

   assign w_uses_rs1 = !((i_opcode == c_op_lui) || (i_opcode == c_op_auipc) ||
                         (i_opcode == c_op_jal));
   assign w_uses_rs2 = (i_opcode == c_op_branch) || (i_opcode == c_op_store) ||
                       (i_opcode == c_op_op);

   assign w_hit = (w_uses_rs1 && (i_rs1 == i_ex_rd)) ||
                  (w_uses_rs2 && (i_rs2 == i_ex_rd));

   // A flush squashes the consumer, so there is nothing left to stall for.
   assign o_stall = !i_flush && i_id_valid && i_ex_valid && i_ex_mem_read &&
                    (i_ex_rd != 5'd0) && w_hit;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with operand bypass and bubbles
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
   import pipeline_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ID_VALID,
   input  logic [31:0] ID_PC,
   input  logic [31:0] ID_IR,
   output logic [4:0]  ADR1,
   output logic [4:0]  ADR2,
   input  logic [31:0] RS1,
   input  logic [31:0] RS2,
   input  logic        WB_EN,
   input  logic [4:0]  WB_WA,
   input  logic [31:0] WB_WD,
   input  logic        FLUSH,
   output logic        STALL,
   output logic        EX_VALID,
   output logic [31:0] EX_PC,
   output logic [31:0] EX_IR,
   output logic [31:0] EX_RS1,
   output logic [31:0] EX_RS2,
   output logic [4:0]  EX_RD,
   output logic        EX_REG_WRITE,
   output logic        EX_MEM_READ
);

   ex_bundle_t r_ex;
   logic       w_reg_write;
   logic       w_mem_read;
   logic       w_stall;

   assign ADR1 = ID_IR[19:15];
   assign ADR2 = ID_IR[24:20];

   hazard_unit u_hazard (
      .i_id_valid    (ID_VALID),
      .i_opcode      (ID_IR[6:0]),
      .i_rd          (ID_IR[11:7]),
      .i_rs1         (ID_IR[19:15]),
      .i_rs2         (ID_IR[24:20]),
      .i_flush       (FLUSH),
      .i_ex_valid    (r_ex.valid),
      .i_ex_mem_read (r_ex.mem_read),
      .i_ex_rd       (r_ex.rd),
      .o_reg_write   (w_reg_write),
      .o_mem_read    (w_mem_read),
      .o_stall       (w_stall)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_ex.valid     <= 1'b0;
         r_ex.pc        <= 32'd0;
         r_ex.ir        <= c_nop;
         r_ex.rs1       <= 32'd0;
         r_ex.rs2       <= 32'd0;
         r_ex.rd        <= 5'd0;
         r_ex.reg_write <= 1'b0;
         r_ex.mem_read  <= 1'b0;
      end else if (FLUSH || w_stall) begin
         // Bubble: only the control fields are cleared; data fields hold.
         r_ex.valid     <= 1'b0;
         r_ex.ir        <= c_nop;
         r_ex.reg_write <= 1'b0;
         r_ex.mem_read  <= 1'b0;
      end else begin
         r_ex.valid     <= ID_VALID;
         r_ex.pc        <= ID_PC;
         r_ex.ir        <= ID_IR;
         r_ex.rs1       <= bypass(WB_EN, WB_WA, WB_WD, ID_IR[19:15], RS1);
         r_ex.rs2       <= bypass(WB_EN, WB_WA, WB_WD, ID_IR[24:20], RS2);
         r_ex.rd        <= ID_IR[11:7];
         r_ex.reg_write <= w_reg_write & ID_VALID;
         r_ex.mem_read  <= w_mem_read & ID_VALID;
      end
   end

   assign STALL        = w_stall;
   assign EX_VALID     = r_ex.valid;
   assign EX_PC        = r_ex.pc;
   assign EX_IR        = r_ex.ir;
   assign EX_RS1       = r_ex.rs1;
   assign EX_RS2       = r_ex.rs2;
   assign EX_RD        = r_ex.rd;
   assign EX_REG_WRITE = r_ex.reg_write;
   assign EX_MEM_READ  = r_ex.mem_read;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ID_VALID;
   logic [31:0] ID_PC;
   logic [31:0] ID_IR;
   logic [4:0]  ADR1;
   logic [4:0]  ADR2;
   logic [31:0] RS1;
   logic [31:0] RS2;
   logic        WB_EN;
   logic [4:0]  WB_WA;
   logic [31:0] WB_WD;
   logic        FLUSH;
   logic        STALL;
   logic        EX_VALID;
   logic [31:0] EX_PC;
   logic [31:0] EX_IR;
   logic [31:0] EX_RS1;
   logic [31:0] EX_RS2;
   logic [4:0]  EX_RD;
   logic        EX_REG_WRITE;
   logic        EX_MEM_READ;

   int r_tests  = 0;
   int r_failed = 0;

   localparam logic [31:0] c_nop     = 32'h0000_0013;
   localparam logic [31:0] c_lw_x5   = 32'h0000_A283; // lw  x5,0(x1)
   localparam logic [31:0] c_add_655 = 32'h0022_8333; // add x6,x5,x2
   localparam logic [31:0] c_sw_x5   = 32'h0051_A023; // sw  x5,0(x3)
   localparam logic [31:0] c_lui_x5  = 32'h1234_52B7; // lui x5,0x12345
   localparam logic [31:0] c_add_87  = 32'h0003_8433; // add x8,x7,x0
   localparam logic [31:0] c_lw_x0   = 32'h0000_A003; // lw  x0,0(x1)
   localparam logic [31:0] c_add_60  = 32'h0020_0333; // add x6,x0,x2
   localparam logic [31:0] c_lw_x9   = 32'h0000_A483; // lw  x9,0(x1)

   always #5 CLK = ~CLK;

   id_ex_stage dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .ID_VALID     (ID_VALID),
      .ID_PC        (ID_PC),
      .ID_IR        (ID_IR),
      .ADR1         (ADR1),
      .ADR2         (ADR2),
      .RS1          (RS1),
      .RS2          (RS2),
      .WB_EN        (WB_EN),
      .WB_WA        (WB_WA),
      .WB_WD        (WB_WD),
      .FLUSH        (FLUSH),
      .STALL        (STALL),
      .EX_VALID     (EX_VALID),
      .EX_PC        (EX_PC),
      .EX_IR        (EX_IR),
      .EX_RS1       (EX_RS1),
      .EX_RS2       (EX_RS2),
      .EX_RD        (EX_RD),
      .EX_REG_WRITE (EX_REG_WRITE),
      .EX_MEM_READ  (EX_MEM_READ)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      r_tests++;
      assert (obs === exp)
      else begin
         r_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic id(input logic v, input logic [31:0] pc, input logic [31:0] ir);
      ID_VALID = v;
      ID_PC    = pc;
      ID_IR    = ir;
      #1;
   endtask

   initial begin
      RST_N = 1'b0; FLUSH = 1'b1; WB_EN = 1'b0; WB_WA = 5'd0; WB_WD = 32'd0;
      RS1 = 32'hAAAA; RS2 = 32'hBBBB;
      id(1'b1, 32'h50, c_lw_x5);

      // Reset overrides a pending flush
      tick();
      FLUSH = 1'b0;
      #1;
      chk("rst_valid", {31'd0, EX_VALID}, 32'd0);
      chk("rst_pc",    EX_PC, 32'd0);
      chk("rst_ir",    EX_IR, c_nop);
      chk("rst_rs1",   EX_RS1, 32'd0);
      chk("rst_rs2",   EX_RS2, 32'd0);
      chk("rst_rd",    {27'd0, EX_RD}, 32'd0);
      chk("rst_rw",    {31'd0, EX_REG_WRITE}, 32'd0);
      chk("rst_mr",    {31'd0, EX_MEM_READ}, 32'd0);
      chk("rst_stall", {31'd0, STALL}, 32'd0);
      RST_N = 1'b1;

      // Load, then dependent add: one stall, one bubble, then the add
      RS1 = 32'h11; RS2 = 32'h22;
      id(1'b1, 32'h100, c_lw_x5);
      chk("lw_adr1", {27'd0, ADR1}, 32'd1);
      chk("lw_adr2", {27'd0, ADR2}, 32'd0);
      chk("lw_stall", {31'd0, STALL}, 32'd0);
      tick();
      chk("lw_valid", {31'd0, EX_VALID}, 32'd1);
      chk("lw_pc",  EX_PC, 32'h100);
      chk("lw_ir",  EX_IR, c_lw_x5);
      chk("lw_rd",  {27'd0, EX_RD}, 32'd5);
      chk("lw_mr",  {31'd0, EX_MEM_READ}, 32'd1);
      chk("lw_rw",  {31'd0, EX_REG_WRITE}, 32'd1);
      chk("lw_rs1", EX_RS1, 32'h11);

      RS1 = 32'h55; RS2 = 32'h66;
      id(1'b1, 32'h104, c_add_655);
      chk("lu_adr1", {27'd0, ADR1}, 32'd5);
      chk("lu_adr2", {27'd0, ADR2}, 32'd2);
      chk("lu_stall", {31'd0, STALL}, 32'd1);
      tick();
      chk("bub_valid", {31'd0, EX_VALID}, 32'd0);
      chk("bub_ir",  EX_IR, c_nop);
      chk("bub_pc",  EX_PC, 32'h100);
      chk("bub_rd",  {27'd0, EX_RD}, 32'd5);
      chk("bub_mr",  {31'd0, EX_MEM_READ}, 32'd0);
      chk("bub_rs1", EX_RS1, 32'h11);
      chk("bub_stall", {31'd0, STALL}, 32'd0);
      tick();
      chk("add_valid", {31'd0, EX_VALID}, 32'd1);
      chk("add_pc",  EX_PC, 32'h104);
      chk("add_rd",  {27'd0, EX_RD}, 32'd6);
      chk("add_rw",  {31'd0, EX_REG_WRITE}, 32'd1);
      chk("add_mr",  {31'd0, EX_MEM_READ}, 32'd0);
      chk("add_rs1", EX_RS1, 32'h55);
      chk("add_rs2", EX_RS2, 32'h66);

      // Write-through bypass on rs1
      RS1 = 32'd0; RS2 = 32'h77;
      WB_EN = 1'b1; WB_WA = 5'd7; WB_WD = 32'hDEADBEEF;
      id(1'b1, 32'h108, c_add_87);
      tick();
      chk("byp_rs1", EX_RS1, 32'hDEADBEEF);
      chk("byp_rs2", EX_RS2, 32'h77);

      // Bypass on rs2
      RS1 = 32'h31; RS2 = 32'h32; WB_WA = 5'd2; WB_WD = 32'hCAFE0002;
      id(1'b1, 32'h10C, c_add_655);
      tick();
      chk("byp2_rs1", EX_RS1, 32'h31);
      chk("byp2_rs2", EX_RS2, 32'hCAFE0002);

      // x0 is never bypassed
      RS1 = 32'hABC; RS2 = 32'h99; WB_WA = 5'd0; WB_WD = 32'h1234;
      id(1'b1, 32'h110, c_add_60);
      tick();
      chk("x0_rs1", EX_RS1, 32'hABC);
      chk("x0_rs2", EX_RS2, 32'h99);
      WB_EN = 1'b0;

      // Load to x0 followed by a use of x0: no stall
      id(1'b1, 32'h114, c_lw_x0);
      tick();
      chk("lwx0_mr", {31'd0, EX_MEM_READ}, 32'd1);
      chk("lwx0_rw", {31'd0, EX_REG_WRITE}, 32'd0);
      id(1'b1, 32'h118, c_add_60);
      chk("x0use_stall", {31'd0, STALL}, 32'd0);
      tick();
      chk("x0use_valid", {31'd0, EX_VALID}, 32'd1);
      chk("x0use_rd", {27'd0, EX_RD}, 32'd6);

      // Flush coinciding with a load-use hazard
      id(1'b1, 32'h120, c_lw_x5);
      tick();
      FLUSH = 1'b1;
      id(1'b1, 32'h124, c_add_655);
      chk("fl_stall", {31'd0, STALL}, 32'd0);
      tick();
      FLUSH = 1'b0;
      chk("fl_valid", {31'd0, EX_VALID}, 32'd0);
      chk("fl_ir", EX_IR, c_nop);
      chk("fl_pc", EX_PC, 32'h120);
      chk("fl_rw", {31'd0, EX_REG_WRITE}, 32'd0);

      // Store consuming the loaded register through rs2
      id(1'b1, 32'h130, c_lw_x5);
      tick();
      id(1'b1, 32'h134, c_sw_x5);
      chk("sw_stall", {31'd0, STALL}, 32'd1);
      tick();
      chk("sw_bub", {31'd0, EX_VALID}, 32'd0);
      chk("sw_stall2", {31'd0, STALL}, 32'd0);
      tick();
      chk("sw_valid", {31'd0, EX_VALID}, 32'd1);
      chk("sw_pc", EX_PC, 32'h134);
      chk("sw_rw", {31'd0, EX_REG_WRITE}, 32'd0);

      // lui does not read rs1
      id(1'b1, 32'h140, c_lw_x5);
      tick();
      id(1'b1, 32'h144, c_lui_x5);
      chk("lui_stall", {31'd0, STALL}, 32'd0);
      tick();
      chk("lui_ir", EX_IR, c_lui_x5);
      chk("lui_rw", {31'd0, EX_REG_WRITE}, 32'd1);

      // Invalid decode slot loads a dead bundle
      id(1'b0, 32'h148, c_lw_x9);
      tick();
      chk("inv_valid", {31'd0, EX_VALID}, 32'd0);
      chk("inv_mr", {31'd0, EX_MEM_READ}, 32'd0);
      chk("inv_rw", {31'd0, EX_REG_WRITE}, 32'd0);
      chk("inv_pc", EX_PC, 32'h148);

      // Reset while stalled discards the stalled bundle
      id(1'b1, 32'h150, c_lw_x5);
      tick();
      id(1'b1, 32'h154, c_add_655);
      chk("rs_stall", {31'd0, STALL}, 32'd1);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      #1;
      chk("rs_valid", {31'd0, EX_VALID}, 32'd0);
      chk("rs_pc", EX_PC, 32'd0);
      chk("rs_rd", {27'd0, EX_RD}, 32'd0);
      chk("rs_ir", EX_IR, c_nop);
      chk("rs_stall2", {31'd0, STALL}, 32'd0);
      tick();
      chk("rs_add_pc", EX_PC, 32'h154);

      $display("[TB] %0d tests run, %0d failed", r_tests, r_failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have: RST_N  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: ID_VALID in 1, ID_PC in 32, ID_IR in 32  decode-stage instruction.
REQ-004 SHALL have: ADR1 out 5, ADR2 out 5  register-file read addresses.
REQ-005 SHALL have: RS1 in 32, RS2 in 32  register-file async read data.
REQ-006 SHALL have: WB_EN in 1, WB_WA in 5, WB_WD in 32  copy of the register-file write port.
REQ-007 SHALL have: FLUSH in 1  squash decode instruction (taken branch/jump).
REQ-008 SHALL have: STALL out 1  hold IF and ID this cycle.
REQ-009 SHALL have: EX_VALID out 1, EX_PC out 32, EX_IR out 32, EX_RS1 out 32, EX_RS2 out 32, EX_RD out 5, EX_REG_WRITE out 1, EX_MEM_READ out 1  registered execute-stage bundle.

Function
REQ-010 ADR1 SHALL equal ID_IR[19:15] and ADR2 SHALL equal ID_IR[24:20], combinationally.
REQ-011 Operand x SHALL be WB_WD when WB_EN=1, WB_WA!=0 and WB_WA==ADRx; else RSx (write-through bypass, same cycle).
REQ-012 reg_write SHALL be 1 for opcodes 0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011 with ID_IR[11:7]!=0; else 0.
REQ-013 mem_read SHALL be 1 only for opcode 0000011.
REQ-014 uses_rs1 SHALL be 1 for all opcodes except 0110111, 0010111, 1101111; uses_rs2 SHALL be 1 only for 1100011, 0100011, 0110011.
REQ-015 STALL SHALL be 1 iff FLUSH=0, ID_VALID=1, EX_VALID=1, EX_MEM_READ=1, EX_RD!=0, and (uses_rs1 and ADR1==EX_RD) or (uses_rs2 and ADR2==EX_RD).
REQ-016 On posedge with FLUSH=1 or STALL=1, SHALL insert bubble: EX_VALID, EX_REG_WRITE, EX_MEM_READ <= 0; EX_IR <= 0x00000013; EX_PC, EX_RS1, EX_RS2, EX_RD hold.
REQ-017 Otherwise SHALL load: EX_VALID<=ID_VALID, EX_PC<=ID_PC, EX_IR<=ID_IR, EX_RS1/EX_RS2<=bypassed operands, EX_RD<=ID_IR[11:7], EX_REG_WRITE<=reg_write&ID_VALID, EX_MEM_READ<=mem_read&ID_VALID.
REQ-018 Latency SHALL be exactly one cycle ID to EX; a stall SHALL last exactly one cycle per load-use pair (bubble clears the condition).
REQ-019 FLUSH SHALL take priority over STALL; simultaneous FLUSH and hazard SHALL produce one bubble and STALL=0.
REQ-020 ID_VALID=0 with no FLUSH SHALL load EX_VALID=0 with controls 0.

Reset
REQ-021 RST_N=0 at posedge SHALL set EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_RD, EX_PC, EX_RS1, EX_RS2 to 0 and EX_IR to 0x00000013, overriding FLUSH and stall.
REQ-022 After reset STALL SHALL read 0 (EX_VALID=0); reset mid-stall SHALL discard the stalled bundle.

Structure
REQ-023 Opcode constants, NOP value 0x00000013 and the EX bundle struct SHALL live in shared package pipeline_pkg.
REQ-024 Decode and load-use detection (REQ-012..015) SHALL be sub-module hazard_unit, purely combinational; pipeline register stays in id_ex_stage.

Verification
REQ-025 Reset: RST_N=0 one cycle -> all EX outputs 0, EX_IR=0x00000013, STALL=0.
REQ-026 Load-use: lw x5,0(x1) then add x6,x5,x2 -> STALL=1 one cycle, bubble, add enters EX next cycle with EX_RD=6.
REQ-027 Bypass: ID add reading x7, WB_EN=1 WB_WA=7 WB_WD=0xDEADBEEF, RS1=0 -> EX_RS1=0xDEADBEEF.
REQ-028 x0: WB_WA=0 WB_WD=0x1234 while ADR1=0 -> EX_RS1=RS1; lw x0 then use x0 -> STALL=0.
REQ-029 Flush+hazard: load-use pair with FLUSH=1 -> STALL=0, EX_VALID=0 next cycle.
REQ-030 Store after load: lw x5 then sw x5,0(x3) -> STALL=1 (uses_rs2); lui x5 after lw x5 -> STALL=0.
